// File: rtl/divisor_frecuencia_multicanal.sv
// -----------------------------------------------------------------------------
// divisor_frecuencia_multicanal
//
// Multi-channel programmable clock/tick divider. Each channel counts clk_in
// cycles up to its half-period H and then wraps to 0 (the terminal event).
// In toggle mode clk_o inverts on every terminal event, giving a period of
// 2*(H+1) cycles. In pulse mode tick_o is high for the single cycle after each
// terminal event.
//
// New settings are written into a per-channel shadow register through a
// valid/ready port. They become active only at a safe point: a terminal
// event, a disabled cycle, or sync_i. Because of this, a period that has
// already started is never cut short.
//
// Ports
//   clk_in       system clock (single domain)
//   rst_i        synchronous active-high reset
//   en_i         per-channel run enable
//   sync_i       restarts every channel at phase 0 and applies pending configs
//   cfg_valid_i  configuration request
//   cfg_ready_o  selected channel has no unapplied configuration
//   cfg_ch_i     target channel; out-of-range values are accepted and dropped
//   cfg_half_i   new half-period H
//   cfg_mode_i   new mode (0 toggle, 1 pulse)
//   clk_o        registered divided clocks (toggle mode)
//   tick_o       registered one-cycle ticks (pulse mode)
//   pending_o    channel holds a configuration that is not yet active
// -----------------------------------------------------------------------------
module divisor_frecuencia_multicanal #(
    parameter int               NUM_CH   = 4,
    parameter int               CNT_W    = 32,
    parameter logic [CNT_W-1:0] HALF_RST = CNT_W'(2499999),
    parameter bit               MODE_RST = 1'b0,
    parameter int               CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst_i,
    input  logic [NUM_CH-1:0] en_i,
    input  logic              sync_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [CNT_W-1:0]  cfg_half_i,
    input  logic              cfg_mode_i,
    output logic [NUM_CH-1:0] clk_o,
    output logic [NUM_CH-1:0] tick_o,
    output logic [NUM_CH-1:0] pending_o
);

    logic [CNT_W-1:0]  cnt      [NUM_CH];
    logic [CNT_W-1:0]  half_act [NUM_CH];
    logic [CNT_W-1:0]  half_shd [NUM_CH];
    logic [NUM_CH-1:0] mode_act;
    logic [NUM_CH-1:0] mode_shd;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] clk_q;
    logic [NUM_CH-1:0] tick_q;

    logic [NUM_CH-1:0] sel;
    logic [NUM_CH-1:0] wr;
    logic [NUM_CH-1:0] term;
    logic [NUM_CH-1:0] load;

    // Channel decode. An out-of-range cfg_ch_i selects no channel. Ready then
    // reads 1 and the write goes nowhere.
    always_comb begin
        sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sel[k] = (cfg_ch_i == CH_W'(k));
        end
    end

    assign cfg_ready_o = ~|(sel & pending);

    always_comb begin
        wr   = sel & {NUM_CH{cfg_valid_i & cfg_ready_o}};
        term = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            term[k] = en_i[k] & (cnt[k] == half_act[k]);
        end
        // Only configurations already pending are applied. A write in this
        // cycle cannot overlap with a load because ready excludes pending.
        load = pending & ({NUM_CH{sync_i}} | ~en_i | term);
    end

    always_ff @(posedge clk_in) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_CH; k++) begin
                cnt[k]      <= '0;
                half_act[k] <= HALF_RST;
                half_shd[k] <= HALF_RST;
            end
            mode_act <= {NUM_CH{MODE_RST}};
            mode_shd <= {NUM_CH{MODE_RST}};
            pending  <= '0;
            clk_q    <= '0;
            tick_q   <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (wr[k]) begin
                    half_shd[k] <= cfg_half_i;
                    mode_shd[k] <= cfg_mode_i;
                    pending[k]  <= 1'b1;
                end else if (load[k]) begin
                    pending[k]  <= 1'b0;
                end

                if (load[k]) begin
                    half_act[k] <= half_shd[k];
                    mode_act[k] <= mode_shd[k];
                end

                if (sync_i || !en_i[k]) begin
                    // sync_i has priority over a terminal event in the same
                    // cycle, so no tick is produced on that cycle.
                    cnt[k]    <= '0;
                    clk_q[k]  <= 1'b0;
                    tick_q[k] <= 1'b0;
                end else if (term[k]) begin
                    cnt[k] <= '0;
                    if (load[k] && (mode_shd[k] != mode_act[k])) begin
                        // A mode switch starts the channel from a clean low level.
                        clk_q[k]  <= 1'b0;
                        tick_q[k] <= 1'b0;
                    end else if (mode_act[k]) begin
                        clk_q[k]  <= 1'b0;
                        tick_q[k] <= 1'b1;
                    end else begin
                        clk_q[k]  <= ~clk_q[k];
                        tick_q[k] <= 1'b0;
                    end
                end else begin
                    // Counter stays <= H because every load restarts it at 0.
                    cnt[k]    <= cnt[k] + CNT_W'(1);
                    tick_q[k] <= 1'b0;
                end
            end
        end
    end

    assign clk_o     = clk_q;
    assign tick_o    = tick_q;
    assign pending_o = pending;

endmodule

// File: tb/tb_divisor_frecuencia_multicanal.sv
module tb_divisor_frecuencia_multicanal;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 4;

    logic             clk_in = 1'b0;
    logic             rst_i  = 1'b1;
    logic [1:0]       en_i   = 2'b00;
    logic             sync_i = 1'b0;
    logic             cfg_valid_i = 1'b0;
    logic             cfg_ready_o;
    logic [0:0]       cfg_ch_i = 1'b0;
    logic [CNT_W-1:0] cfg_half_i = '0;
    logic             cfg_mode_i = 1'b0;
    logic [1:0]       clk_o;
    logic [1:0]       tick_o;
    logic [1:0]       pending_o;

    divisor_frecuencia_multicanal #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .HALF_RST (4'd3),
        .MODE_RST (1'b0)
    ) dut (
        .clk_in      (clk_in),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .sync_i      (sync_i),
        .cfg_valid_i (cfg_valid_i),
        .cfg_ready_o (cfg_ready_o),
        .cfg_ch_i    (cfg_ch_i),
        .cfg_half_i  (cfg_half_i),
        .cfg_mode_i  (cfg_mode_i),
        .clk_o       (clk_o),
        .tick_o      (tick_o),
        .pending_o   (pending_o)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0] en;
        logic       valid;
        logic       ch;
        logic [3:0] half;
        logic       mode;
        logic [1:0] x_clk;
        logic [1:0] x_tick;
        logic [1:0] x_pend;
        logic       x_rdy;
    } vec_t;

    vec_t tbl [20];

    logic [1:0] e_en;
    logic       e_sync, e_valid, e_ch, e_mode;
    logic [3:0] e_half;
    logic [1:0] x_clk, x_tick, x_pend;
    logic       x_rdy;

    function automatic vec_t mk(input logic [1:0] en, input logic valid, input logic ch,
                                input logic [3:0] half, input logic mode,
                                input logic [1:0] xc, input logic [1:0] xt,
                                input logic [1:0] xp, input logic xr);
        vec_t v;
        v.en = en; v.valid = valid; v.ch = ch; v.half = half; v.mode = mode;
        v.x_clk = xc; v.x_tick = xt; v.x_pend = xp; v.x_rdy = xr;
        return v;
    endfunction

    task automatic chk(input string name, input int w, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s window %0d: got %0h expected %0h", name, w, act, exp);
        end
    endtask

    task automatic check_all(input string name, input int w, input logic [1:0] xc,
                             input logic [1:0] xt, input logic [1:0] xp, input logic xr);
        chk({name, ".clk_o"},       w, 32'(clk_o),       32'(xc));
        chk({name, ".tick_o"},      w, 32'(tick_o),      32'(xt));
        chk({name, ".pending_o"},   w, 32'(pending_o),   32'(xp));
        chk({name, ".cfg_ready_o"}, w, 32'(cfg_ready_o), 32'(xr));
    endtask

    task automatic apply_in(input logic [1:0] en, input logic sync, input logic valid,
                            input logic ch, input logic [3:0] half, input logic mode);
        en_i        = en;
        sync_i      = sync;
        cfg_valid_i = valid;
        cfg_ch_i    = ch;
        cfg_half_i  = half;
        cfg_mode_i  = mode;
    endtask

    // Leaves the bench at the start of window 0: reset has been sampled and the
    // next rising edge is the first one that counts.
    task automatic do_reset();
        @(negedge clk_in);
        rst_i = 1'b1;
        apply_in(2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        @(negedge clk_in);
        rst_i = 1'b0;
    endtask

    task automatic clear_e();
        e_en = 2'b11; e_sync = 1'b0; e_valid = 1'b0; e_ch = 1'b0; e_half = 4'd0; e_mode = 1'b0;
    endtask

    initial begin
        // Defaults H=3 toggle on both channels; ch1 reprogrammed to H=4 pulse.
        tbl[0]  = mk(2'b11, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
        tbl[1]  = mk(2'b11, 1'b1, 1'b1, 4'd4, 1'b1, 2'b00, 2'b00, 2'b00, 1'b1);
        tbl[2]  = mk(2'b11, 1'b0, 1'b1, 4'd0, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0);
        tbl[3]  = mk(2'b11, 1'b0, 1'b1, 4'd0, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0);
        tbl[4]  = mk(2'b11, 1'b0, 1'b1, 4'd0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1);
        tbl[5]  = mk(2'b11, 1'b0, 1'b0, 4'd0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1);
        tbl[6]  = mk(2'b11, 1'b0, 1'b0, 4'd0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1);
        tbl[7]  = mk(2'b11, 1'b0, 1'b0, 4'd0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1);
        tbl[8]  = mk(2'b11, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
        tbl[9]  = mk(2'b11, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b1);
        tbl[10] = mk(2'b11, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
        tbl[11] = mk(2'b11, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
        tbl[12] = mk(2'b11, 1'b0, 1'b0, 4'd0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1);
        tbl[13] = mk(2'b11, 1'b0, 1'b0, 4'd0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1);
        tbl[14] = mk(2'b11, 1'b0, 1'b0, 4'd0, 1'b0, 2'b01, 2'b10, 2'b00, 1'b1);
        tbl[15] = mk(2'b11, 1'b0, 1'b0, 4'd0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1);
        tbl[16] = mk(2'b11, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
        tbl[17] = mk(2'b11, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
        tbl[18] = mk(2'b11, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
        tbl[19] = mk(2'b11, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b1);

        // Table: reset defaults, then pulse mode on ch1.
        do_reset();
        for (int w = 0; w < 20; w++) begin
            apply_in(tbl[w].en, 1'b0, tbl[w].valid, tbl[w].ch, tbl[w].half, tbl[w].mode);
            #1;
            check_all("tbl", w, tbl[w].x_clk, tbl[w].x_tick, tbl[w].x_pend, tbl[w].x_rdy);
            @(negedge clk_in);
        end

        // Glitch-free update H=9 -> 2, then a write that has to wait for ready.
        do_reset();
        for (int w = 0; w < 27; w++) begin
            clear_e();
            e_en = (w < 2) ? 2'b00 : 2'b01;
            if (w == 0) begin e_valid = 1'b1; e_half = 4'd9; end
            else if (w == 5) begin e_valid = 1'b1; e_half = 4'd2; end
            else if (w >= 7 && w <= 12) begin e_valid = 1'b1; e_half = 4'd5; end
            apply_in(e_en, e_sync, e_valid, e_ch, e_half, e_mode);
            #1;
            x_pend = {1'b0, (w == 1) || (w >= 6 && w <= 11) || (w == 13) || (w == 14)};
            x_clk  = {1'b0, (w >= 12 && w <= 14) || (w >= 21)};
            check_all("upd", w, x_clk, 2'b00, x_pend, ~x_pend[0]);
            @(negedge clk_in);
        end

        // sync_i aligning two channels at different phases.
        do_reset();
        for (int w = 0; w < 17; w++) begin
            clear_e();
            e_en   = (w < 2) ? 2'b01 : 2'b11;
            e_sync = (w == 6);
            apply_in(e_en, e_sync, e_valid, e_ch, e_half, e_mode);
            #1;
            if (w < 4) x_clk = 2'b00;
            else if (w < 6) x_clk = 2'b01;
            else if (w == 6) x_clk = 2'b11;
            else if (w < 11) x_clk = 2'b00;
            else if (w < 15) x_clk = 2'b11;
            else x_clk = 2'b00;
            check_all("sync", w, x_clk, 2'b00, 2'b00, 1'b1);
            @(negedge clk_in);
        end

        // Pulse mode with sync_i on a terminal cycle that also applies a pending write.
        do_reset();
        for (int w = 0; w < 16; w++) begin
            clear_e();
            e_en   = (w < 2) ? 2'b00 : 2'b01;
            e_sync = (w == 7);
            if (w == 0) begin e_valid = 1'b1; e_half = 4'd2; e_mode = 1'b1; end
            else if (w == 5) begin e_valid = 1'b1; e_half = 4'd1; e_mode = 1'b1; end
            apply_in(e_en, e_sync, e_valid, e_ch, e_half, e_mode);
            #1;
            x_tick = {1'b0, (w == 5) || (w == 10) || (w == 12) || (w == 14)};
            x_pend = {1'b0, (w == 1) || (w == 6) || (w == 7)};
            check_all("psync", w, 2'b00, x_tick, x_pend, ~x_pend[0]);
            @(negedge clk_in);
        end

        // Disable applies pending (H=0 -> clk_in/2), then reset mid-run.
        do_reset();
        for (int w = 0; w < 18; w++) begin
            clear_e();
            e_en  = (w == 5) ? 2'b10 : 2'b11;
            rst_i = (w == 9);
            if (w == 4) begin e_valid = 1'b1; e_half = 4'd0; end
            else if (w == 9) begin e_valid = 1'b1; e_ch = 1'b1; e_half = 4'd7; end
            apply_in(e_en, e_sync, e_valid, e_ch, e_half, e_mode);
            #1;
            x_clk[0] = (w == 4) || (w == 5) || (w == 7) || (w == 9) || (w >= 14);
            x_clk[1] = (w >= 4 && w <= 7) || (w >= 14);
            x_pend   = {1'b0, (w == 5)};
            check_all("dis", w, x_clk, 2'b00, x_pend, (w != 5));
            @(negedge clk_in);
        end
        rst_i = 1'b0;

        // Largest half-period (15) on ch0, H=0 pulse (tick held high) on ch1.
        do_reset();
        for (int w = 0; w < 36; w++) begin
            clear_e();
            e_en = (w < 2) ? 2'b00 : ((w == 2) ? 2'b01 : 2'b11);
            if (w == 0) begin e_valid = 1'b1; e_half = 4'd15; end
            else if (w == 1) begin e_valid = 1'b1; e_ch = 1'b1; e_half = 4'd0; e_mode = 1'b1; end
            apply_in(e_en, e_sync, e_valid, e_ch, e_half, e_mode);
            #1;
            x_clk  = {1'b0, (w >= 18 && w <= 33)};
            x_tick = {(w >= 4), 1'b0};
            x_pend = (w == 1) ? 2'b01 : ((w == 2) ? 2'b10 : 2'b00);
            check_all("max", w, x_clk, x_tick, x_pend, 1'b1);
            @(negedge clk_in);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/divisor_frecuencia_multicanal.md
Name: divisor_frecuencia_multicanal

Overview:
- Parametrised multi-channel clock/tick divider.
- Each channel divides clk_in by a runtime-programmable half-period.
- Each channel runs in toggle mode (square clock enable) or pulse mode (1-cycle tick).
- Configuration uses a valid/ready port; new settings take effect glitch-free at the channel's terminal count. A global sync_i phase-aligns all channels.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16)
- CNT_W, 32, counter and divisor width in bits
- HALF_RST, 2499999, per-channel half-period loaded at reset (10 MHz -> 2 Hz toggle)
- MODE_RST, 0, per-channel mode at reset (0 = toggle, 1 = pulse)
- CH_W, $clog2(NUM_CH) (min 1), channel select width (derived)

Ports:
- clk_in  input  1  system clock; single clock domain
- rst_i  input  1  synchronous, active-high reset
- en_i  input  NUM_CH  per-channel run enable
- sync_i  input  1  restarts all enabled channels at phase 0
- cfg_valid_i  input  1  configuration request
- cfg_ready_o  output  1  channel cfg_ch_i can accept a configuration
- cfg_ch_i  input  CH_W  target channel
- cfg_half_i  input  CNT_W  new half-period value H
- cfg_mode_i  input  1  new mode (0 toggle, 1 pulse)
- clk_o  output  NUM_CH  divided square outputs (toggle mode)
- tick_o  output  NUM_CH  one-cycle pulses (pulse mode)
- pending_o  output  NUM_CH  channel holds an unapplied configuration

Behaviour:
- Reset, sampled on posedge clk_in with rst_i = 1:
  - counters = 0; active H = HALF_RST; active mode = MODE_RST; shadow = active values.
  - clk_o = 0, tick_o = 0, pending_o = 0, cfg_ready_o = 1.
  - rst_i overrides every other input, including mid-operation.
- Counting, channel enabled:
  - Counter increments each cycle. When counter == H it returns to 0 (terminal event).
  - Toggle mode: clk_o inverts on the terminal event, giving period 2*(H+1) cycles at 50% duty. tick_o = 0.
  - Pulse mode: tick_o = 1 for exactly the one cycle following the terminal event, i.e. one pulse every H+1 cycles. clk_o = 0.
  - H = 0: toggle mode gives clk_in/2; pulse mode holds tick_o continuously high.
  - All outputs are registered; no combinational path from inputs to clk_o or tick_o.
- Disabled channel (en_i[k] = 0):
  - Counter held at 0; clk_o[k] = 0 and tick_o[k] = 0 from the next cycle.
  - Any pending configuration is applied on the next cycle.
- On re-enable, counting starts from 0; the first toggle or tick occurs after H+1 cycles.
- Configuration handshake:
  - cfg_ready_o = ~pending[cfg_ch_i] (combinational on cfg_ch_i).
  - Transfer occurs when cfg_valid_i & cfg_ready_o. Shadow[cfg_ch_i] <= {cfg_half_i, cfg_mode_i}; pending[cfg_ch_i] <= 1.
  - cfg_ch_i >= NUM_CH: cfg_ready_o = 1 and the write is dropped. No state changes.
- Apply: shadow is copied to active and pending is cleared on the first of the following:
  - a terminal event;
  - a disabled cycle;
  - sync_i.
- On apply, the counter restarts at 0.
  - If the mode changed, clk_o is forced to 0.
  - If the mode is unchanged, the toggle/tick belonging to that terminal event still occurs.
  - This gives no runt pulses: the old period always completes.
- Simultaneous events:
  - A configuration accepted in cycle t is pending from t+1. A terminal event or sync_i in cycle t uses only the configuration already pending before t.
  - sync_i outranks a terminal event in the same cycle: all counters go to 0 and all clk_o go to 0. No tick is generated; pending configurations are applied.
  - sync_i held high keeps all channels at phase 0.
- Width rules:
  - Counter and comparison are unsigned CNT_W bits.
  - H = 2^CNT_W - 1 is legal; the counter never overflows because it wraps at H.

Test Plan:
- Reset / defaults: NUM_CH=2, HALF_RST=3, en_i=2'b11, toggle mode -> clk_o toggles every 4 cycles (period 8); pending_o=0; cfg_ready_o=1.
- Pulse mode: write ch1 H=4, mode=1 -> after the current period ends, tick_o[1] is high 1 cycle every 5 cycles; clk_o[1]=0.
- Glitch-free update: ch0 running H=9; write H=2 at counter=3 -> pending_o[0]=1 and cfg_ready_o=0 for ch0 until counter reaches 9; the old 10-cycle half completes, then 3-cycle halves follow.
- Backpressure: a second write to ch0 while pending -> no handshake; shadow is unchanged; the request is accepted the cycle after the apply.
- sync_i: channels at different phases, pulse sync_i -> all counters 0 and clk_o 0 the next cycle; all channels toggle together after H+1 cycles. Sync on a terminal cycle -> no tick.
- Disable / reset mid-run: en_i[0]=0 -> clk_o[0]=0 the next cycle and pending is applied; rst_i during counting -> all outputs 0 and H=HALF_RST the next cycle.
